floor_request_scheduler: RTL and testbench

- Upstream of the elevator control FSM.
- Debounces the four cabin floor buttons and latches cabin and hall calls into pending-request registers.
- Selects the next target floor with a SCAN (keep-direction) policy and presents it to the FSM.
- Clears requests when the FSM reports arrival at a floor; exports the pending mask for display/debug.

---
 rtl/floor_request_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_floor_request_scheduler.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/floor_request_scheduler.sv
// -----------------------------------------------------------------------------
// floor_request_scheduler
//
// Sits between the raw call inputs and the elevator control FSM. It
// synchronizes and debounces the four cabin buttons, latches cabin and hall
// calls into pending registers, and picks the next target floor with a SCAN
// (keep travelling in the same direction) policy.
//
// Ports:
//   clk           system clock, everything on the rising edge
//   reset         synchronous active-high reset, clears all state
//   cab_btn[3:0]  raw cabin buttons (async to clk), bit i = floor i
//   hall_valid    one-cycle pulse qualifying hall_floor / hall_up
//   hall_floor    hall call floor 0..3
//   hall_up       1 = hall call wants to go up, 0 = down
//   current_floor floor the car is at or last passed
//   arrive        one-cycle pulse, car stopped at current_floor
//   req_valid     at least one request is pending (registered)
//   req_floor     selected target floor (registered)
//   req_up        direction of travel toward req_floor (registered)
//   pending_mask  per-floor OR of cabin, hall-up and hall-down pending bits
// -----------------------------------------------------------------------------
module floor_request_scheduler #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cab_btn,
    input  logic       hall_valid,
    input  logic [1:0] hall_floor,
    input  logic       hall_up,
    input  logic [1:0] current_floor,
    input  logic       arrive,
    output logic       req_valid,
    output logic [1:0] req_floor,
    output logic       req_up,
    output logic [3:0] pending_mask
);

    typedef enum logic [1:0] {
        SCAN_IDLE = 2'd0,
        SCAN_UP   = 2'd1,
        SCAN_DOWN = 2'd2
    } scan_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]            sync1_q, sync1_d;
    logic [3:0]            sync2_q, sync2_d;
    logic [3:0]            deb_q, deb_d;
    logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]            cab_pend_q, cab_pend_d;
    logic [3:0]            up_pend_q, up_pend_d;
    logic [3:0]            dn_pend_q, dn_pend_d;
    scan_state_t           state_q, state_d;
    logic                  req_valid_q, req_valid_d;
    logic [1:0]            req_floor_q, req_floor_d;
    logic                  req_up_q, req_up_d;

    logic [3:0] cab_rise;
    logic [3:0] hall_up_set;
    logic [3:0] hall_dn_set;
    logic [3:0] clear_mask;
    logic       any_at_or_above;
    logic       any_at_or_below;
    logic [1:0] up_target;
    logic [1:0] dn_target;

    assign pending_mask = cab_pend_q | up_pend_q | dn_pend_q;
    assign req_valid    = req_valid_q;
    assign req_floor    = req_floor_q;
    assign req_up       = req_up_q;

    // Two-flop synchronizer followed by a per-bit debounce counter. The
    // counter only runs while the synced level disagrees with the accepted
    // level, so DEBOUNCE_CYCLES consecutive disagreeing samples flip it.
    always_comb begin
        sync1_d  = cab_btn;
        sync2_d  = sync1_q;
        deb_d    = deb_q;
        cnt_d    = cnt_q;
        cab_rise = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    deb_d[i]    = ~deb_q[i];
                    cnt_d[i]    = '0;
                    cab_rise[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    // Pending request registers. Hall calls that point out of the shaft are
    // dropped. A clear from arrive is applied after the sets, so a call made
    // at the floor whose doors are opening is treated as already served.
    always_comb begin
        hall_up_set = '0;
        hall_dn_set = '0;
        clear_mask  = '0;
        if (hall_valid) begin
            if (hall_up && (hall_floor != 2'd3)) begin
                hall_up_set[hall_floor] = 1'b1;
            end else if (!hall_up && (hall_floor != 2'd0)) begin
                hall_dn_set[hall_floor] = 1'b1;
            end
        end
        if (arrive) begin
            clear_mask[current_floor] = 1'b1;
        end
        cab_pend_d = (cab_pend_q | cab_rise) & ~clear_mask;
        up_pend_d  = (up_pend_q | hall_up_set) & ~clear_mask;
        dn_pend_d  = (dn_pend_q | hall_dn_set) & ~clear_mask;
    end

    // Candidate targets in each direction. The upward scan runs top-down so
    // the last hit is the lowest floor at or above the car; the downward scan
    // runs bottom-up so the last hit is the highest floor at or below it.
    always_comb begin
        any_at_or_above = 1'b0;
        any_at_or_below = 1'b0;
        up_target       = 2'd0;
        dn_target       = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pending_mask[i] && (2'(i) >= current_floor)) begin
                any_at_or_above = 1'b1;
                up_target       = 2'(i);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (pending_mask[i] && (2'(i) <= current_floor)) begin
                any_at_or_below = 1'b1;
                dn_target       = 2'(i);
            end
        end
    end

    // SCAN next-state and output logic. The outputs follow the next state, so
    // whenever the next state is UP or DOWN a target in that direction is
    // guaranteed to exist; in IDLE nothing is pending and the target holds.
    always_comb begin
        state_d     = state_q;
        req_valid_d = |pending_mask;
        req_floor_d = req_floor_q;
        req_up_d    = req_up_q;
        case (state_q)
            SCAN_IDLE: begin
                if (any_at_or_above) begin
                    state_d = SCAN_UP;
                end else if (any_at_or_below) begin
                    state_d = SCAN_DOWN;
                end
            end
            SCAN_UP: begin
                if (any_at_or_above) begin
                    state_d = SCAN_UP;
                end else if (any_at_or_below) begin
                    state_d = SCAN_DOWN;
                end else begin
                    state_d = SCAN_IDLE;
                end
            end
            SCAN_DOWN: begin
                if (any_at_or_below) begin
                    state_d = SCAN_DOWN;
                end else if (any_at_or_above) begin
                    state_d = SCAN_UP;
                end else begin
                    state_d = SCAN_IDLE;
                end
            end
            default: begin
                state_d = SCAN_IDLE;
            end
        endcase
        if (state_d == SCAN_UP) begin
            req_floor_d = up_target;
            req_up_d    = 1'b1;
        end else if (state_d == SCAN_DOWN) begin
            req_floor_d = dn_target;
            req_up_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_q       <= '0;
            cnt_q       <= '0;
            cab_pend_q  <= '0;
            up_pend_q   <= '0;
            dn_pend_q   <= '0;
            state_q     <= SCAN_IDLE;
            req_valid_q <= 1'b0;
            req_floor_q <= 2'd0;
            req_up_q    <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            deb_q       <= deb_d;
            cnt_q       <= cnt_d;
            cab_pend_q  <= cab_pend_d;
            up_pend_q   <= up_pend_d;
            dn_pend_q   <= dn_pend_d;
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            req_floor_q <= req_floor_d;
            req_up_q    <= req_up_d;
        end
    end

endmodule

// File: tb/tb_floor_request_scheduler.sv
// -----------------------------------------------------------------------------
// tb_floor_request_scheduler
//
// Drives directed scenarios followed by random traffic into
// floor_request_scheduler (DEBOUNCE_CYCLES = 4). Each driven cycle runs a
// behavioural model and queues the expected post-edge outputs; a monitor on
// the falling edge pops and compares them against the DUT.
// -----------------------------------------------------------------------------
module tb_floor_request_scheduler;

    localparam int DEB = 4;

    typedef struct {
        int         edge_no;
        logic [3:0] pend;
        logic       valid;
        logic [1:0] floor;
        logic       up;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] cab_btn;
    logic       hall_valid;
    logic [1:0] hall_floor;
    logic       hall_up;
    logic [1:0] current_floor;
    logic       arrive;
    logic       req_valid;
    logic [1:0] req_floor;
    logic       req_up;
    logic [3:0] pending_mask;

    int total = 0;
    int bad = 0;
    int edge_count = 0;
    exp_t exp_q[$];

    // Model state: synchronizer pipe, sample history per button, accepted
    // button level, pending calls per floor and the scan direction.
    logic        m_s1[4];
    logic        m_s2[4];
    logic [15:0] m_hist[4];
    int          m_hist_len[4];
    logic        m_deb[4];
    logic        m_cab[4];
    logic        m_upc[4];
    logic        m_dnc[4];
    int          m_dir;
    logic [1:0]  m_req_floor;
    logic        m_req_up;
    logic        m_req_valid;

    floor_request_scheduler #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cab_btn(cab_btn),
        .hall_valid(hall_valid),
        .hall_floor(hall_floor),
        .hall_up(hall_up),
        .current_floor(current_floor),
        .arrive(arrive),
        .req_valid(req_valid),
        .req_floor(req_floor),
        .req_up(req_up),
        .pending_mask(pending_mask)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_count <= edge_count + 1;

    // Scoreboard monitor: compare every expectation whose edge has happened.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].edge_no <= edge_count) begin
            e = exp_q.pop_front();
            total++;
            if ({pending_mask, req_valid, req_floor, req_up} !== {e.pend, e.valid, e.floor, e.up}) begin
                bad++;
                $display("[TB] FAIL scoreboard edge %0d: got pend=%b valid=%b floor=%0d up=%b, want pend=%b valid=%b floor=%0d up=%b",
                         e.edge_no, pending_mask, req_valid, req_floor, req_up, e.pend, e.valid, e.floor, e.up);
            end
        end
    end

    // One clock edge of the reference model, derived from the call rules:
    // a button is accepted after DEB consecutive synced samples disagree with
    // the accepted level; the scan keeps direction while calls remain ahead.
    task automatic modelStep(input logic r, input logic [3:0] b, input logic hv_i,
                             input logic [1:0] hf_i, input logic hu_i,
                             input logic [1:0] cf_i, input logic ar_i);
        exp_t e;
        bit   any_p;
        bit   ahead_up;
        bit   ahead_dn;
        int   lo_t;
        int   hi_t;
        int   nd;
        bit   all_diff;
        bit   rose[4];
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_hist[i] = '0; m_hist_len[i] = 0;
                m_deb[i] = 0; m_cab[i] = 0; m_upc[i] = 0; m_dnc[i] = 0;
            end
            m_dir = 0; m_req_floor = 2'd0; m_req_up = 0; m_req_valid = 0;
        end else begin
            any_p = 0; ahead_up = 0; ahead_dn = 0; lo_t = -1; hi_t = -1;
            for (int f = 0; f < 4; f++) begin
                if (m_cab[f] || m_upc[f] || m_dnc[f]) begin
                    any_p = 1;
                    if (f >= int'(cf_i)) begin
                        ahead_up = 1;
                        if (lo_t < 0) lo_t = f;
                    end
                    if (f <= int'(cf_i)) begin
                        ahead_dn = 1;
                        hi_t = f;
                    end
                end
            end
            nd = 0;
            if (m_dir == 2 && ahead_dn) nd = 2;
            else if (ahead_up) nd = 1;
            else if (any_p) nd = 2;
            m_dir = nd;
            m_req_valid = any_p;
            if (nd == 1) begin
                m_req_floor = 2'(lo_t); m_req_up = 1;
            end else if (nd == 2) begin
                m_req_floor = 2'(hi_t); m_req_up = 0;
            end
            for (int i = 0; i < 4; i++) begin
                rose[i] = 0;
                m_hist[i] = {m_hist[i][14:0], m_s2[i]};
                if (m_hist_len[i] < 16) m_hist_len[i]++;
                all_diff = (m_hist_len[i] >= DEB);
                for (int k = 0; k < DEB; k++) begin
                    if (m_hist[i][k] == m_deb[i]) all_diff = 0;
                end
                if (all_diff) begin
                    m_deb[i] = ~m_deb[i];
                    rose[i] = m_deb[i];
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = b[i];
            end
            for (int f = 0; f < 4; f++) begin
                if (rose[f]) m_cab[f] = 1;
                if (hv_i && hu_i && hf_i == 2'(f) && f != 3) m_upc[f] = 1;
                if (hv_i && !hu_i && hf_i == 2'(f) && f != 0) m_dnc[f] = 1;
                if (ar_i && cf_i == 2'(f)) begin
                    m_cab[f] = 0; m_upc[f] = 0; m_dnc[f] = 0;
                end
            end
        end
        e.edge_no = edge_count + 1;
        for (int f = 0; f < 4; f++) e.pend[f] = m_cab[f] | m_upc[f] | m_dnc[f];
        e.valid = m_req_valid;
        e.floor = m_req_floor;
        e.up    = m_req_up;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs, predict it, and return #1 after the edge.
    task automatic applyStimulus(input logic r, input logic [3:0] b, input logic hv_i,
                                 input logic [1:0] hf_i, input logic hu_i,
                                 input logic [1:0] cf_i, input logic ar_i);
        reset = r; cab_btn = b; hall_valid = hv_i; hall_floor = hf_i;
        hall_up = hu_i; current_floor = cf_i; arrive = ar_i;
        modelStep(r, b, hv_i, hf_i, hu_i, cf_i, ar_i);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    initial begin
        logic [3:0] rb;
        logic [1:0] rcf;

        // Power-up reset.
        applyStimulus(1, 4'b0000, 0, 2'd0, 0, 2'd0, 0);
        applyStimulus(1, 4'b0000, 0, 2'd0, 0, 2'd0, 0);
        checkOutput("reset_pending", 8'(pending_mask), 8'h0);
        checkOutput("reset_valid", 8'(req_valid), 8'h0);

        // A 3-cycle glitch on button 2 must be rejected.
        repeat (3) applyStimulus(0, 4'b0100, 0, 2'd0, 0, 2'd1, 0);
        repeat (7) applyStimulus(0, 4'b0000, 0, 2'd0, 0, 2'd1, 0);
        checkOutput("glitch_rejected", 8'(pending_mask), 8'h0);

        // A held press is accepted exactly 2 + DEB cycles after the rise.
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(0, 4'b0100, 0, 2'd0, 0, 2'd1, 0);
            if (k == 5) checkOutput("debounce_not_early", 8'(pending_mask), 8'h0);
            if (k == 6) checkOutput("debounce_latency", 8'(pending_mask), 8'h4);
        end
        repeat (8) applyStimulus(0, 4'b0000, 0, 2'd0, 0, 2'd1, 0);

        // Reset in the middle of operation.
        applyStimulus(1, 4'b0000, 0, 2'd0, 0, 2'd1, 0);
        checkOutput("midreset_pending", 8'(pending_mask), 8'h0);
        checkOutput("midreset_req", {5'd0, req_valid, req_floor}, 8'h0);
        checkOutput("midreset_up", 8'(req_up), 8'h0);

        // SCAN upward from floor 1 with calls at 3 and 0.
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(0, 4'b1001, 0, 2'd0, 0, 2'd1, 0);
            if (k == 6) checkOutput("scan_pend_1001", 8'(pending_mask), 8'h9);
        end
        checkOutput("scan_up_target", {5'd0, req_valid, req_floor}, 8'h7);
        checkOutput("scan_up_dir", 8'(req_up), 8'h1);

        // A nearer call at floor 2 retargets one cycle after it latches.
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(0, 4'b0100, 0, 2'd0, 0, 2'd1, 0);
            if (k == 6) checkOutput("retarget_before", 8'(req_floor), 8'h3);
        end
        checkOutput("retarget_after", 8'(req_floor), 8'h2);

        // Serve floor 2, climb to 3, serve it, then reverse toward floor 0.
        applyStimulus(0, 4'b0000, 0, 2'd0, 0, 2'd2, 1);
        applyStimulus(0, 4'b0000, 0, 2'd0, 0, 2'd3, 0);
        checkOutput("at3_target", 8'(req_floor), 8'h3);
        applyStimulus(0, 4'b0000, 0, 2'd0, 0, 2'd3, 1);
        checkOutput("arrive3_clear", 8'(pending_mask), 8'h1);
        applyStimulus(0, 4'b0000, 0, 2'd0, 0, 2'd3, 0);
        checkOutput("reverse_target", {5'd0, req_valid, req_floor}, 8'h4);
        checkOutput("reverse_dir", 8'(req_up), 8'h0);

        // Hall calls: up at the top floor is ignored, down at 2 is kept.
        applyStimulus(1, 4'b0000, 0, 2'd0, 0, 2'd0, 0);
        applyStimulus(0, 4'b0000, 1, 2'd3, 1, 2'd0, 0);
        checkOutput("hall_up_top_ignored", 8'(pending_mask), 8'h0);
        applyStimulus(0, 4'b0000, 1, 2'd2, 0, 2'd0, 0);
        checkOutput("hall_down_2", 8'(pending_mask), 8'h4);

        // Arrive at 2 with a hall call there and a cabin call at 0 landing
        // in the same cycle: the floor-2 calls clear, floor 0 is kept.
        repeat (5) applyStimulus(0, 4'b0001, 0, 2'd0, 0, 2'd2, 0);
        applyStimulus(0, 4'b0001, 1, 2'd2, 1, 2'd2, 1);
        checkOutput("set_clear_same_cycle", 8'(pending_mask), 8'h1);

        // Random traffic against the model.
        rb = 4'b0000;
        rcf = 2'd0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 9) == 0) rb[i] = ~rb[i];
            end
            if ($urandom_range(0, 5) == 0) rcf = 2'($urandom_range(0, 3));
            applyStimulus(($urandom_range(0, 299) == 0), rb,
                          ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), rcf,
                          ($urandom_range(0, 4) == 0));
        end
        applyStimulus(0, 4'b0000, 0, 2'd0, 0, rcf, 0);

        // Let the monitor drain; anything left unchecked is an error.
        repeat (3) @(negedge clk);
        #1;
        checkOutput("scoreboard_drained", 8'(exp_q.size()), 8'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
